dac_sequencer: RTL and testbench

DAC_SEQUENCER -- requirements
Module: dac_sequencer

---
 rtl/dac_sequencer.sv | 171 +++++++++++++++++
 tb/tb_dac_sequencer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/dac_sequencer.sv
// Sequences one precharge phase, eight MSB-first bit phases and a done pulse for a DAC.
// Latency: first PRE cycle follows the edge that samples start; total (comp+1)+8*(conver+1)+1 cycles.
// No backpressure: start is level-sampled in IDLE/DONE only and ignored while a conversion runs.
module dac_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       vref_vld,
    input  logic [3:0] vref,
    input  logic       data_vld,
    input  logic [7:0] data,
    input  logic       conver_vld,
    input  logic [7:0] conver,
    input  logic       comp_vld,
    input  logic [5:0] comp,
    input  logic       start,
    output logic [2:0] VR,
    output logic [2:0] VM,
    output logic [2:0] VRC,
    output logic       busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PRE  = 2'd1;
    localparam logic [1:0] S_BIT  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0] r_state;
    logic [7:0] r_cnt;
    logic [2:0] r_idx;
    logic [3:0] r_vref;
    logic [7:0] r_data;
    logic [7:0] r_conver;
    logic [5:0] r_comp;
    logic [2:0] r_vr;
    logic [2:0] r_vm;
    logic [2:0] r_vrc;
    logic       r_busy;

    logic       w_go;
    logic [1:0] w_nstate;
    logic [7:0] w_ncnt;
    logic [2:0] w_nidx;
    logic [3:0] w_nvref;
    logic [7:0] w_ndata;
    logic [7:0] w_nconver;
    logic [5:0] w_ncomp;
    logic [2:0] w_nvr;
    logic [2:0] w_nvm;
    logic [2:0] w_nvrc;
    logic       w_nbusy;
    logic       w_nbit;

    assign w_go = start & vref_vld & data_vld & conver_vld & comp_vld;

    // Next state, phase counter, bit index and operand latches.
    always_comb begin
        w_nstate  = r_state;
        w_ncnt    = r_cnt;
        w_nidx    = r_idx;
        w_nvref   = r_vref;
        w_ndata   = r_data;
        w_nconver = r_conver;
        w_ncomp   = r_comp;
        case (r_state)
            S_IDLE: begin
                if (w_go) begin
                    w_nstate  = S_PRE;
                    w_ncnt    = 8'd0;
                    w_nvref   = vref;
                    w_ndata   = data;
                    w_nconver = conver;
                    w_ncomp   = comp;
                end
            end
            S_PRE: begin
                if (r_cnt == {2'b00, r_comp}) begin
                    w_nstate = S_BIT;
                    w_nidx   = 3'd7;
                    w_ncnt   = 8'd0;
                end else begin
                    w_ncnt = r_cnt + 8'd1;
                end
            end
            S_BIT: begin
                if (r_cnt == r_conver) begin
                    w_ncnt = 8'd0;
                    if (r_idx == 3'd0) begin
                        w_nstate = S_DONE;
                    end else begin
                        w_nidx = r_idx - 3'd1;
                    end
                end else begin
                    w_ncnt = r_cnt + 8'd1;
                end
            end
            default: begin
                // DONE: chain straight into another conversion in continuous mode.
                if (r_vref[3] && w_go) begin
                    w_nstate  = S_PRE;
                    w_ncnt    = 8'd0;
                    w_nvref   = vref;
                    w_ndata   = data;
                    w_nconver = conver;
                    w_ncomp   = comp;
                end else begin
                    w_nstate = S_IDLE;
                end
            end
        endcase
    end

    // Output values for the upcoming cycle, derived from next state so outputs can be registered.
    always_comb begin
        w_nvr   = 3'b000;
        w_nvm   = 3'b000;
        w_nvrc  = 3'b000;
        w_nbusy = (w_nstate != S_IDLE);
        w_nbit  = w_ndata[w_nidx];
        case (w_nstate)
            S_PRE: begin
                w_nvr = w_nvref[2:0];
            end
            S_BIT: begin
                w_nvr  = w_nbit ? 3'b010 : 3'b100;
                w_nvm  = w_nidx;
                w_nvrc = {1'b0, w_nbit, (w_ncnt == w_nconver)};
            end
            S_DONE: begin
                w_nvrc = 3'b100;
            end
            default: begin
                w_nvr = 3'b000;
            end
        endcase
    end

    // State and output registers; reset aborts any conversion without a done pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= 8'd0;
            r_idx    <= 3'd0;
            r_vref   <= 4'd0;
            r_data   <= 8'd0;
            r_conver <= 8'd0;
            r_comp   <= 6'd0;
            r_vr     <= 3'd0;
            r_vm     <= 3'd0;
            r_vrc    <= 3'd0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_nstate;
            r_cnt    <= w_ncnt;
            r_idx    <= w_nidx;
            r_vref   <= w_nvref;
            r_data   <= w_ndata;
            r_conver <= w_nconver;
            r_comp   <= w_ncomp;
            r_vr     <= w_nvr;
            r_vm     <= w_nvm;
            r_vrc    <= w_nvrc;
            r_busy   <= w_nbusy;
        end
    end

    assign VR   = r_vr;
    assign VM   = r_vm;
    assign VRC  = r_vrc;
    assign busy = r_busy;

endmodule

// File: tb/tb_dac_sequencer.sv
// Directed bench for dac_sequencer with a per-cycle expected-output scoreboard.
// Latency: checks every cycle from the first PRE cycle to DONE.
// Backpressure: none; start is pulsed or held as each scenario needs.
module tb_dac_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       vref_vld, data_vld, conver_vld, comp_vld, start;
    logic [3:0] vref;
    logic [7:0] data, conver;
    logic [5:0] comp;
    logic [2:0] VR, VM, VRC;
    logic       busy;

    typedef logic [9:0] vec_t;   // {busy, VR, VM, VRC}

    vec_t q[$];
    int   vectors    = 0;
    int   miscompares = 0;
    int   busy_cnt   = 0;
    int   done_cnt   = 0;

    always #5 clk = ~clk;

    dac_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .vref_vld   (vref_vld),
        .vref       (vref),
        .data_vld   (data_vld),
        .data       (data),
        .conver_vld (conver_vld),
        .conver     (conver),
        .comp_vld   (comp_vld),
        .comp       (comp),
        .start      (start),
        .VR         (VR),
        .VM         (VM),
        .VRC        (VRC),
        .busy       (busy)
    );

    task automatic check(input string tag, input vec_t exp);
        vec_t o;
        o = {busy, VR, VM, VRC};
        vectors++;
        assert (o === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, o, exp);
        end
    endtask

    task automatic check_int(input string tag, input int o, input int exp);
        vectors++;
        assert (o === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, o, exp);
        end
    endtask

    // Expected cycle-by-cycle outputs for one conversion.
    task automatic push_conv(input logic [3:0] v, input logic [7:0] d,
                             input logic [7:0] cv, input logic [5:0] cp);
        for (int i = 0; i <= int'(cp); i++)
            q.push_back({1'b1, v[2:0], 3'b000, 3'b000});
        for (int b = 7; b >= 0; b--)
            for (int c = 0; c <= int'(cv); c++)
                q.push_back({1'b1, (d[b] ? 3'b010 : 3'b100), 3'(b),
                             1'b0, d[b], (c == int'(cv))});
        q.push_back({1'b1, 3'b000, 3'b000, 3'b100});
    endtask

    task automatic drain(input int n, input string tag);
        vec_t e;
        repeat (n) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (VRC[2]) done_cnt++;
            if (q.size() == 0) begin
                vectors++;
                miscompares++;
                $error("FAIL %s observed=scoreboard-empty expected=entry", tag);
            end else begin
                e = q.pop_front();
                check(tag, e);
            end
        end
    endtask

    task automatic idle_check(input int n, input string tag);
        repeat (n) begin
            @(negedge clk);
            if (VRC[2]) done_cnt++;
            check(tag, 10'b0);
        end
    endtask

    // Drive operands, pulse start across one sampling edge.
    task automatic start_conv(input logic [3:0] v, input logic [7:0] d,
                              input logic [7:0] cv, input logic [5:0] cp);
        vref = v; data = d; conver = cv; comp = cp;
        vref_vld = 1'b1; data_vld = 1'b1; conver_vld = 1'b1; comp_vld = 1'b1;
        push_conv(v, d, cv, cp);
        busy_cnt = 0;
        done_cnt = 0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        vref_vld = 1'b0; data_vld = 1'b0; conver_vld = 1'b0; comp_vld = 1'b0;
        start = 1'b0; vref = 4'h0; data = 8'h00; conver = 8'h00; comp = 6'h00;
        #2 check("reset_async", 10'b0);
        idle_check(2, "reset_hold");
        rst = 1'b1;

        // A5, single-cycle phases: DONE on cycle 10.
        start_conv(4'h3, 8'hA5, 8'd0, 6'd0);
        drain(10, "a5_seq");
        check_int("a5_done_pulses", done_cnt, 1);
        idle_check(2, "a5_idle");

        // Long phases; operand changes mid-run must not matter.
        start_conv(4'h6, 8'hFF, 8'd3, 6'd5);
        drain(20, "ff_seq");
        data = 8'h00; conver = 8'd0; comp = 6'd0; vref = 4'h0;
        drain(19, "ff_seq_late");
        check_int("ff_busy_cycles", busy_cnt, 39);
        idle_check(2, "ff_idle");

        // start held while comp_vld low: no conversion until it rises.
        vref = 4'h2; data = 8'h3C; conver = 8'd0; comp = 6'd1;
        vref_vld = 1'b1; data_vld = 1'b1; conver_vld = 1'b1; comp_vld = 1'b0;
        start = 1'b1;
        idle_check(4, "vld_wait");
        comp_vld = 1'b1;
        push_conv(4'h2, 8'h3C, 8'd0, 6'd1);
        @(posedge clk);
        #1 start = 1'b0;
        drain(11, "vld_seq");
        idle_check(2, "vld_idle");

        // Continuous mode: back-to-back conversions, second uses new data.
        vref = 4'hB; data = 8'h5A; conver = 8'd0; comp = 6'd1;
        push_conv(4'hB, 8'h5A, 8'd0, 6'd1);
        done_cnt = 0;
        start = 1'b1;
        @(posedge clk);
        #1;
        drain(11, "cont_first");
        data = 8'hC3;
        push_conv(4'hB, 8'hC3, 8'd0, 6'd1);
        drain(1, "cont_no_idle");
        start = 1'b0;
        drain(10, "cont_second");
        check_int("cont_done_pulses", done_cnt, 2);
        idle_check(2, "cont_idle");

        // Reset during bit index 4 aborts with no done pulse.
        start_conv(4'h1, 8'hF0, 8'd1, 6'd0);
        drain(8, "rst_pre");
        #1 rst = 1'b0;
        #1 check("rst_async_mid", 10'b0);
        q.delete();
        done_cnt = 0;
        idle_check(2, "rst_held");
        rst = 1'b1;
        #1 check("rst_release", 10'b0);
        check_int("rst_no_done", done_cnt, 0);
        start_conv(4'h1, 8'hF0, 8'd1, 6'd0);
        drain(18, "rst_restart");
        check_int("rst_restart_done", done_cnt, 1);
        idle_check(2, "rst_idle");

        // All-zero data with a stray start during BIT.
        start_conv(4'h7, 8'h00, 8'd1, 6'd0);
        drain(3, "zero_pre");
        start = 1'b1;
        drain(1, "zero_restart_ignored");
        start = 1'b0;
        drain(14, "zero_seq");
        idle_check(3, "zero_idle");
        check_int("zero_done_pulses", done_cnt, 1);

        check_int("scoreboard_empty", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
